ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the swt16 5-stage pipeline, sitting between decode and the memory stage.
- Registers decoded operands and computes the integer ALU result.
- Forms DMEM load/store addresses and the store word.
- Forwards the control actions the memory stage consumes on the next cycle.
- Runs an iterative multi-cycle multiplier and stalls decode while it runs.

Parameters:
DMEM_ADDR_WIDTH, 12, DMEM address width
DMEM_WORD_WIDTH, 16, DMEM data word width
IALU_WORD_WIDTH, 16, ALU operand/result width
ALU_OP_WIDTH, 4, ALU operation code width
PMEM_WORD_WIDTH, 16, instruction word width
REG_IDX_WIDTH, 4, register index width

Ports:
clock  in  1  stage clock
reset  in  1  synchronous, active-high reset
in_instr  in  PMEM_WORD_WIDTH  instruction from decode (0 = bubble)
in_alu_op  in  ALU_OP_WIDTH  ALU operation select
in_op_a  in  IALU_WORD_WIDTH  operand A / address base
in_op_b  in  IALU_WORD_WIDTH  operand B / store data
in_imm  in  IALU_WORD_WIDTH  sign-extended immediate
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
in_act_load_dmem  in  1  instruction is a load
in_act_store_dmem  in  1  instruction is a store
in_act_write_res_to_reg  in  1  instruction writes the register file
out_stall  out  1  decode must hold its outputs
out_instr  out  PMEM_WORD_WIDTH  registered instruction
out_act_load_dmem  out  1  registered load action
out_act_store_dmem  out  1  registered store action
out_act_write_res_to_reg  out  1  registered writeback action
out_mem_rd_addr  out  DMEM_ADDR_WIDTH  load address
out_mem_wr_addr  out  DMEM_ADDR_WIDTH  store address
out_mem_wr_word  out  DMEM_WORD_WIDTH  store data
out_res  out  IALU_WORD_WIDTH  ALU result
out_res_reg_idx  out  REG_IDX_WIDTH  registered destination index

Behaviour:
- Clocking and reset: single clock `clock`; `reset` is synchronous and active-high.
- Reset: every output register is 0, state IDLE, out_stall=0, multiplier accumulator/counter cleared.
- Reset asserted mid-multiply aborts the operation; no result is emitted.
- Latency: in IDLE, all outputs are registered one cycle after the inputs (1-cycle latency). The memory stage drives DMEM combinationally from these registers.
- ALU ops (codes 0-7): ADD, SUB, AND, OR, XOR, SHL, SHR, MUL.
  - Arithmetic wraps modulo 2^IALU_WORD_WIDTH.
  - Shift amount is in_op_b[3:0]; SHR is logical.
  - MUL returns the low IALU_WORD_WIDTH bits of the product.
  - Undefined codes give out_res=0; the action bits pass through unchanged.
- Loads/stores:
  - rd_addr = wr_addr = (in_op_a + in_imm) truncated to DMEM_ADDR_WIDTH.
  - wr_word = in_op_b.
  - Address registers update for every instruction; only the act bits qualify them.
- FSM state IDLE:
  - A non-bubble instruction with in_alu_op=MUL latches op_a, op_b, instr, reg_idx and the act bits.
  - State goes to MUL_BUSY with counter=0.
  - Outputs register a bubble that cycle: instr and all act bits 0.
- FSM state MUL_BUSY:
  - out_stall=1; decode holds its outputs and ex ignores its inputs.
  - One shift-add iteration per cycle; counter increments.
  - Outputs keep registering a bubble.
  - At counter = IALU_WORD_WIDTH-1, the final product and the latched instr/act/reg_idx are registered to the outputs and the state returns to IDLE.
  - out_stall is therefore high for exactly 16 cycles. The result is visible 17 edges after the accept edge.
- Back-to-back MUL: the second MUL is accepted in the first IDLE cycle after completion.
- Simultaneous store and write_res acts are passed through as given; ex does not arbitrate.

Optional Feature:
EX_MUL_EN
- Defined: iterative multiplier, FSM and out_stall behave as above.
- Undefined: no multiplier or FSM is synthesised and out_stall is tied 0. MUL behaves as an undefined code (out_res=0, 1-cycle latency, act bits passed through).

Decomposition:
- Package swt16_pkg: ALU op codes (ALU_ADD..ALU_MUL), FSM state encodings (EX_IDLE, EX_MUL_BUSY), default width constants.
- One natural sub-module: ex_mul_iter, the shift-add datapath.
  - Inputs: start, a, b.
  - Outputs: busy, done, product.
  - Instantiated only under EX_MUL_EN.

Test Plan:
- Reset held 2 cycles during random inputs -> all outputs 0, out_stall=0; reset released -> first ADD 3+4 gives out_res=7 one cycle later.
- Wrap: ADD 0xFFFF+0x0002 -> out_res=0x0001. SUB 0x0000-0x0001 -> 0xFFFF. SHR 0x8000 by 15 -> 0x0001.
- Load: op_a=0x0FF0, imm=0x0020, act_load=1 -> out_mem_rd_addr=0x010 (12-bit wrap), out_act_load_dmem=1. Store with op_b=0xBEEF -> out_mem_wr_word=0xBEEF, out_act_store_dmem=1.
- MUL 0x0123*0x0045 with write_res=1, reg_idx=5 -> out_stall high exactly 16 cycles, bubbles meanwhile, then out_res=0x4E6F, reg_idx=5, write_res=1 for one cycle. Held decode instruction is executed next.
- Reset asserted at iteration 8 of a MUL -> next cycle outputs 0, state IDLE, no result ever emitted.
- Build without EX_MUL_EN: MUL 3*5 -> out_res=0 after 1 cycle, out_stall never asserted.

Source files
------------

// File: rtl/swt16_pkg.sv
// rtl/swt16_pkg.sv - swt16 shared ALU op codes, execute-stage FSM states and default widths
package swt16_pkg;

  localparam int SWT16_DMEM_ADDR_WIDTH = 12;
  localparam int SWT16_DMEM_WORD_WIDTH = 16;
  localparam int SWT16_IALU_WORD_WIDTH = 16;
  localparam int SWT16_ALU_OP_WIDTH    = 4;
  localparam int SWT16_PMEM_WORD_WIDTH = 16;
  localparam int SWT16_REG_IDX_WIDTH   = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_MUL = 4'd7
  } alu_op_e;

  typedef enum logic {
    EX_IDLE     = 1'b0,
    EX_MUL_BUSY = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
// start loads a/b; done is high in the last busy cycle with the final product on product.
module ex_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_next;

  // Only the low WIDTH bits are kept, so wrap-around in acc/mcand is intended.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product = acc_next;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - swt16 execute stage: ALU, DMEM address/data, action forwarding
// Define EX_MUL_EN to build the iterative multiplier and decode stall; otherwise MUL yields 0.
module ex_stage
  import swt16_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = SWT16_DMEM_ADDR_WIDTH,
  parameter int DMEM_WORD_WIDTH = SWT16_DMEM_WORD_WIDTH,
  parameter int IALU_WORD_WIDTH = SWT16_IALU_WORD_WIDTH,
  parameter int ALU_OP_WIDTH    = SWT16_ALU_OP_WIDTH,
  parameter int PMEM_WORD_WIDTH = SWT16_PMEM_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = SWT16_REG_IDX_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_a,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_b,
  input  logic [IALU_WORD_WIDTH-1:0] in_imm,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  output logic                       out_stall,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  logic [PMEM_WORD_WIDTH-1:0] instr_q, instr_d;
  logic                       ld_q, ld_d, st_q, st_d, wr_q, wr_d;
  logic [DMEM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DMEM_WORD_WIDTH-1:0] wr_word_q, wr_word_d;
  logic [IALU_WORD_WIDTH-1:0] res_q, res_d;
  logic [REG_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                       stall_q, stall_d;

  logic [IALU_WORD_WIDTH-1:0] ea_sum;
  logic [IALU_WORD_WIDTH-1:0] alu_res;
  logic [3:0]                 shamt;

  always_comb begin
    ea_sum = in_op_a + in_imm;
    shamt  = in_op_b[3:0];
    case (in_alu_op)
      ALU_ADD: alu_res = in_op_a + in_op_b;
      ALU_SUB: alu_res = in_op_a - in_op_b;
      ALU_AND: alu_res = in_op_a & in_op_b;
      ALU_OR:  alu_res = in_op_a | in_op_b;
      ALU_XOR: alu_res = in_op_a ^ in_op_b;
      ALU_SHL: alu_res = in_op_a << shamt;
      ALU_SHR: alu_res = in_op_a >> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_e                  state_q, state_d;
  logic [PMEM_WORD_WIDTH-1:0] lat_instr_q, lat_instr_d;
  logic [REG_IDX_WIDTH-1:0]   lat_idx_q, lat_idx_d;
  logic                       lat_ld_q, lat_ld_d, lat_st_q, lat_st_d, lat_wr_q, lat_wr_d;
  logic                       mul_start, mul_busy, mul_done;
  logic [IALU_WORD_WIDTH-1:0] mul_product;

  ex_mul_iter #(
    .WIDTH(IALU_WORD_WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (in_op_a),
    .b       (in_op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    instr_d   = in_instr;
    ld_d      = in_act_load_dmem;
    st_d      = in_act_store_dmem;
    wr_d      = in_act_write_res_to_reg;
    rd_addr_d = ea_sum[DMEM_ADDR_WIDTH-1:0];
    wr_addr_d = ea_sum[DMEM_ADDR_WIDTH-1:0];
    wr_word_d = in_op_b[DMEM_WORD_WIDTH-1:0];
    res_d     = alu_res;
    idx_d     = in_res_reg_idx;
    stall_d   = 1'b0;
`ifdef EX_MUL_EN
    state_d     = state_q;
    lat_instr_d = lat_instr_q;
    lat_idx_d   = lat_idx_q;
    lat_ld_d    = lat_ld_q;
    lat_st_d    = lat_st_q;
    lat_wr_d    = lat_wr_q;
    mul_start   = 1'b0;
    if (state_q == EX_IDLE) begin
      if (in_instr != '0 && in_alu_op == ALU_MUL) begin
        mul_start   = 1'b1;
        state_d     = EX_MUL_BUSY;
        stall_d     = 1'b1;
        lat_instr_d = in_instr;
        lat_idx_d   = in_res_reg_idx;
        lat_ld_d    = in_act_load_dmem;
        lat_st_d    = in_act_store_dmem;
        lat_wr_d    = in_act_write_res_to_reg;
        instr_d     = '0;
        ld_d        = 1'b0;
        st_d        = 1'b0;
        wr_d        = 1'b0;
      end
    end else begin
      // Decode is held, so the inputs are stale: emit bubbles until the product is ready.
      instr_d   = '0;
      ld_d      = 1'b0;
      st_d      = 1'b0;
      wr_d      = 1'b0;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_word_d = wr_word_q;
      res_d     = res_q;
      idx_d     = idx_q;
      stall_d   = mul_busy;
      if (mul_done) begin
        state_d = EX_IDLE;
        stall_d = 1'b0;
        instr_d = lat_instr_q;
        ld_d    = lat_ld_q;
        st_d    = lat_st_q;
        wr_d    = lat_wr_q;
        res_d   = mul_product;
        idx_d   = lat_idx_q;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q   <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_word_q <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      stall_q   <= 1'b0;
`ifdef EX_MUL_EN
      state_q     <= EX_IDLE;
      lat_instr_q <= '0;
      lat_idx_q   <= '0;
      lat_ld_q    <= 1'b0;
      lat_st_q    <= 1'b0;
      lat_wr_q    <= 1'b0;
`endif
    end else begin
      instr_q   <= instr_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      wr_q      <= wr_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_word_q <= wr_word_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      stall_q   <= stall_d;
`ifdef EX_MUL_EN
      state_q     <= state_d;
      lat_instr_q <= lat_instr_d;
      lat_idx_q   <= lat_idx_d;
      lat_ld_q    <= lat_ld_d;
      lat_st_q    <= lat_st_d;
      lat_wr_q    <= lat_wr_d;
`endif
    end
  end

  assign out_stall                = stall_q;
  assign out_instr                = instr_q;
  assign out_act_load_dmem        = ld_q;
  assign out_act_store_dmem       = st_q;
  assign out_act_write_res_to_reg = wr_q;
  assign out_mem_rd_addr          = rd_addr_q;
  assign out_mem_wr_addr          = wr_addr_q;
  assign out_mem_wr_word          = wr_word_q;
  assign out_res                  = res_q;
  assign out_res_reg_idx          = idx_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
// Follows EX_MUL_EN the same way the design does.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_instr, in_op_a, in_op_b, in_imm;
  logic [3:0]  in_alu_op, in_res_reg_idx;
  logic        in_ld, in_st, in_wr;

  logic        out_stall, out_ld, out_st, out_wr;
  logic [15:0] out_instr, out_mem_wr_word, out_res;
  logic [11:0] out_mem_rd_addr, out_mem_wr_addr;
  logic [3:0]  out_res_reg_idx;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_instr                 (in_instr),
    .in_alu_op                (in_alu_op),
    .in_op_a                  (in_op_a),
    .in_op_b                  (in_op_b),
    .in_imm                   (in_imm),
    .in_res_reg_idx           (in_res_reg_idx),
    .in_act_load_dmem         (in_ld),
    .in_act_store_dmem        (in_st),
    .in_act_write_res_to_reg  (in_wr),
    .out_stall                (out_stall),
    .out_instr                (out_instr),
    .out_act_load_dmem        (out_ld),
    .out_act_store_dmem       (out_st),
    .out_act_write_res_to_reg (out_wr),
    .out_mem_rd_addr          (out_mem_rd_addr),
    .out_mem_wr_addr          (out_mem_wr_addr),
    .out_mem_wr_word          (out_mem_wr_word),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_res_reg_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected outputs after the most recent edge.
  logic        e_stall, e_ld, e_st, e_wr;
  logic [15:0] e_instr, e_res, e_word;
  logic [11:0] e_addr;
  logic [3:0]  e_idx;
  logic        chk_data, chk_addr;
  int          busy_left = 0;
  logic        stall_before = 1'b0;
  logic [15:0] p_instr, p_a, p_b;
  logic [3:0]  p_idx;
  logic        p_ld, p_st, p_wr;

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    case (op)
      4'd0: r = 32'(a) + 32'(b);
      4'd1: r = 32'(a) - 32'(b);
      4'd2: r = 32'(a & b);
      4'd3: r = 32'(a | b);
      4'd4: r = 32'(a ^ b);
      4'd5: r = 32'(a) << b[3:0];
      4'd6: r = 32'(a) >> b[3:0];
      default: r = 32'd0;
    endcase
    return r[15:0];
  endfunction

  task automatic model_edge();
    logic [31:0] prod;
    if (reset) begin
      e_stall = 0; e_instr = 0; e_ld = 0; e_st = 0; e_wr = 0;
      e_res = 0; e_idx = 0; e_addr = 0; e_word = 0;
      chk_data = 1; chk_addr = 1; busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      e_instr = 0; e_ld = 0; e_st = 0; e_wr = 0;
      e_stall = 1; chk_data = 0; chk_addr = 0;
      if (busy_left == 0) begin
        prod = 32'(p_a) * 32'(p_b);
        e_stall = 0; e_instr = p_instr; e_ld = p_ld; e_st = p_st; e_wr = p_wr;
        e_res = prod[15:0]; e_idx = p_idx; chk_data = 1;
      end
    end
`ifdef EX_MUL_EN
    else if (in_instr != 16'd0 && in_alu_op == 4'd7) begin
      p_instr = in_instr; p_a = in_op_a; p_b = in_op_b; p_idx = in_res_reg_idx;
      p_ld = in_ld; p_st = in_st; p_wr = in_wr;
      busy_left = 16;
      e_stall = 1; e_instr = 0; e_ld = 0; e_st = 0; e_wr = 0;
      chk_data = 0; chk_addr = 0;
    end
`endif
    else begin
      e_stall = 0; e_instr = in_instr; e_ld = in_ld; e_st = in_st; e_wr = in_wr;
      e_res = ref_alu(in_alu_op, in_op_a, in_op_b);
      e_idx = in_res_reg_idx;
      e_addr = 12'((in_op_a + in_imm) % 16'h1000);
      e_word = in_op_b;
      chk_data = 1; chk_addr = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    stall_before = e_stall;
    model_edge();
    @(negedge clock);
    check("stall", 32'(out_stall), 32'(e_stall));
    check("instr", 32'(out_instr), 32'(e_instr));
    check("act_ld", 32'(out_ld), 32'(e_ld));
    check("act_st", 32'(out_st), 32'(e_st));
    check("act_wr", 32'(out_wr), 32'(e_wr));
    if (chk_data) begin
      check("res", 32'(out_res), 32'(e_res));
      check("res_idx", 32'(out_res_reg_idx), 32'(e_idx));
    end
    if (chk_addr) begin
      check("rd_addr", 32'(out_mem_rd_addr), 32'(e_addr));
      check("wr_addr", 32'(out_mem_wr_addr), 32'(e_addr));
      check("wr_word", 32'(out_mem_wr_word), 32'(e_word));
    end
  endtask

  task automatic drive(input logic [15:0] instr, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic [3:0] idx,
                       input logic ld, input logic st, input logic wr);
    in_instr = instr; in_alu_op = op; in_op_a = a; in_op_b = b; in_imm = imm;
    in_res_reg_idx = idx; in_ld = ld; in_st = st; in_wr = wr;
  endtask

  task automatic drive_random();
    drive(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
          ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
          16'($urandom), 16'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int stall_cnt;
    logic saw_result;

    reset = 1'b1;
    drive_random();
    cycle();
    drive_random();
    cycle();
    check("rst_res", 32'(out_res), 32'd0);
    check("rst_stall", 32'(out_stall), 32'd0);
    check("rst_instr", 32'(out_instr), 32'd0);

    reset = 1'b0;
    drive(16'h0101, 4'd0, 16'd3, 16'd4, 16'd0, 4'd1, 0, 0, 1);
    cycle();
    check("add_3_4", 32'(out_res), 32'd7);
    drive(16'h0102, 4'd0, 16'hFFFF, 16'h0002, 16'd0, 4'd2, 0, 0, 1);
    cycle();
    check("add_wrap", 32'(out_res), 32'h0001);
    drive(16'h0103, 4'd1, 16'h0000, 16'h0001, 16'd0, 4'd2, 0, 0, 1);
    cycle();
    check("sub_wrap", 32'(out_res), 32'hFFFF);
    drive(16'h0104, 4'd6, 16'h8000, 16'd15, 16'd0, 4'd2, 0, 0, 1);
    cycle();
    check("shr_15", 32'(out_res), 32'h0001);
    drive(16'h0105, 4'd0, 16'h0FF0, 16'h0000, 16'h0020, 4'd3, 1, 0, 1);
    cycle();
    check("load_addr", 32'(out_mem_rd_addr), 32'h010);
    check("load_act", 32'(out_ld), 32'd1);
    drive(16'h0106, 4'd0, 16'h0100, 16'hBEEF, 16'h0004, 4'd0, 0, 1, 0);
    cycle();
    check("store_word", 32'(out_mem_wr_word), 32'hBEEF);
    check("store_act", 32'(out_st), 32'd1);
    check("store_addr", 32'(out_mem_wr_addr), 32'h104);

`ifdef EX_MUL_EN
    drive(16'h0707, 4'd7, 16'h0123, 16'h0045, 16'd0, 4'd5, 0, 0, 1);
    cycle();
    check("mul_accept_bubble", 32'(out_instr), 32'd0);
    drive(16'h1111, 4'd0, 16'd1, 16'd2, 16'd0, 4'd3, 0, 0, 1);
    stall_cnt = out_stall ? 1 : 0;
    for (int k = 0; k < 40 && out_stall; k++) begin
      cycle();
      if (out_stall) stall_cnt++;
    end
    check("mul_stall_cycles", 32'(stall_cnt), 32'd16);
    check("mul_res", 32'(out_res), 32'h4E6F);
    check("mul_idx", 32'(out_res_reg_idx), 32'd5);
    check("mul_wr", 32'(out_wr), 32'd1);
    check("mul_instr", 32'(out_instr), 32'h0707);
    cycle();
    check("held_add_res", 32'(out_res), 32'd3);
    check("held_add_instr", 32'(out_instr), 32'h1111);

    drive(16'h0708, 4'd7, 16'h1234, 16'h0055, 16'd0, 4'd6, 0, 0, 1);
    cycle();
    drive(16'h0000, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle();
    reset = 1'b1;
    cycle();
    check("abort_stall", 32'(out_stall), 32'd0);
    check("abort_res", 32'(out_res), 32'd0);
    check("abort_wr", 32'(out_wr), 32'd0);
    reset = 1'b0;
    saw_result = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (out_wr || out_instr != 16'd0 || out_stall) saw_result = 1'b1;
    end
    check("abort_no_result", 32'(saw_result), 32'd0);
`else
    drive(16'h0707, 4'd7, 16'd3, 16'd5, 16'd0, 4'd5, 0, 0, 1);
    cycle();
    check("nomul_res", 32'(out_res), 32'd0);
    check("nomul_stall", 32'(out_stall), 32'd0);
    check("nomul_wr", 32'(out_wr), 32'd1);
    check("nomul_instr", 32'(out_instr), 32'h0707);
`endif

    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (!stall_before) drive_random();
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
